// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the control unit and the mult/div unit
interface mult_div_if #(parameter int WIDTH = 32);
  logic             op_start;
  logic             op_sel;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master (output op_start, op_sel, a_in, b_in, input busy, done, div_zero, hi_out, lo_out);
  modport slave  (input op_start, op_sel, a_in, b_in, output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide on magnitudes with a final sign fix-up
module mult_div_unit #(parameter int WIDTH = 32) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     ma_q, ma_d, mb_q, mb_d, rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
  logic               op_q, op_d, sa_q, sa_d, neg_q, neg_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag, sum_m, shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s, r_s;
  assign a_ext   = {bus.a_in[WIDTH-1], bus.a_in};
  assign b_ext   = {bus.b_in[WIDTH-1], bus.b_in};
  assign a_mag   = a_ext[WIDTH] ? -a_ext : a_ext;
  assign b_mag   = b_ext[WIDTH] ? -b_ext : b_ext;
  // mult: add multiplicand into the upper half when the low multiplier bit is set, then shift right
  assign sum_m   = rem_q + (quo_q[0] ? ma_q : '0);
  // div: restoring step, extra top bit of diff is the borrow
  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {1'b0, mb_q};
  assign prod_s  = neg_q ? -{rem_q[WIDTH-1:0], quo_q} : {rem_q[WIDTH-1:0], quo_q};
  assign q_s     = neg_q ? -quo_q : quo_q;
  assign r_s     = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    sa_d    = sa_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.op_start && !done_q) begin
        ma_d    = a_mag;
        mb_d    = b_mag;
        op_d    = bus.op_sel;
        sa_d    = bus.a_in[WIDTH-1];
        neg_d   = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = bus.op_sel ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0];
        dz_d    = bus.op_sel && bus.b_in == '0;
        state_d = dz_d ? DONE : CALC;
      end
      CALC: begin
        rem_d   = op_q ? (diff[WIDTH+1] ? shifted : diff[WIDTH:0]) : {1'b0, sum_m[WIDTH:1]};
        quo_d   = op_q ? {quo_q[WIDTH-2:0], ~diff[WIDTH+1]} : {sum_m[0], quo_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(WIDTH - 1) ? FIX : CALC;
      end
      FIX: begin
        hi_d    = op_q ? r_s : prod_s[2*WIDTH-1:WIDTH];
        lo_d    = op_q ? q_s : prod_s[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign bus.busy     = state_q != IDLE || done_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
endmodule
